// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared types and constants for the memory-stage SRAM controller.
//   state_t            : controller FSM states
//   CNT_W              : width of the per-phase hold counter (WAIT_CYCLES <= 15)
//   DEFAULT_BASE_ADDR  : byte address that maps onto SRAM word 0
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int CNT_W = 4;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_phase_timer.sv
// -----------------------------------------------------------------------------
// sram_phase_timer
// Loadable down-counter timing one half-word phase. After a load of N it
// counts N, N-1, ..., 0 and then rests at 0, so a phase lasts N+1 cycles.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset (count -> 0)
//   load      in   load load_val on the next edge (has priority)
//   load_val  in   CNT_W-bit reload value
//   zero      out  count is 0 (final cycle of the phase)
// -----------------------------------------------------------------------------
module sram_phase_timer
    import sram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of process evaluation order.
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sram_mem_ctrl.sv
// -----------------------------------------------------------------------------
// sram_mem_ctrl
// Memory-stage controller: performs one 32-bit load or store against a 16-bit
// asynchronous SRAM as two half-word phases (low half first). ready drops
// while an access is in flight so the pipeline freezes and holds the request.
//
// Optional feature (compile-time macro SRAM_CTRL_RANGE_CHECK_EN):
//   adds output addr_err; out-of-range requests skip the SRAM phases, go
//   straight to DONE and flag addr_err for that one cycle.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   rd_en, wr_en         load / store request (write wins if both)
//   address              byte address (bits [1:0] ignored)
//   write_data           store data
//   read_data            registered load result, held until the next load
//   ready                0 = freeze the pipeline
//   addr_err             (macro only) range fault, high during DONE
//   sram_addr            half-word address {word, hi}
//   sram_dq_o/_i/_oe     data pad out / in / driver enable
//   sram_ce_n/oe_n/we_n  active-low chip, output and write enables
// -----------------------------------------------------------------------------
module sram_mem_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          SRAM_ADDR_W = 18,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    output logic                   addr_err,
`endif
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_o,
    input  logic [15:0]            sram_dq_i,
    output logic                   sram_dq_oe,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n
);

    localparam int               WORD_W    = SRAM_ADDR_W - 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t            state;
    state_t            state_next;
    logic              op_wr;
    logic [WORD_W-1:0] word;
    logic [31:0]       wdata;
    logic [15:0]       lo_half;

    logic              req;
    logic              range_fault;
    logic [WORD_W-1:0] word_in;
    logic              timer_load;
    logic              timer_zero;
    logic              active;
    logic              in_hi;

    assign req = rd_en | wr_en;

    // Word index relative to BASE_ADDR; truncation gives the modulo wrap for
    // addresses below the base.
    assign word_in = WORD_W'((address - BASE_ADDR) >> 2);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    // Any offset bit at or above the word-index width means overflow.
    assign range_fault = (address < BASE_ADDR) ||
                         (((address - BASE_ADDR) >> (SRAM_ADDR_W + 1)) != 32'd0);
`else
    assign range_fault = 1'b0;
`endif

    sram_phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (WAIT_LOAD),
        .zero     (timer_zero)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, timer control and SRAM pin decode
    always_comb begin
        // NOTE: every output gets a default first, so no path can leave a
        // variable unassigned and infer a latch.
        state_next = state;
        timer_load = 1'b0;
        active     = 1'b0;
        in_hi      = 1'b0;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        sram_addr  = '0;
        sram_dq_o  = '0;

        case (state)
            IDLE: begin
                if (req) begin
                    if (range_fault) begin
                        state_next = DONE;
                    end else begin
                        state_next = ACC_LO;
                        timer_load = 1'b1;
                    end
                end
            end
            ACC_LO: begin
                active = 1'b1;
                if (timer_zero) begin
                    state_next = ACC_HI;
                    timer_load = 1'b1;
                end
            end
            ACC_HI: begin
                active = 1'b1;
                in_hi  = 1'b1;
                if (timer_zero) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (active) begin
            sram_ce_n  = 1'b0;
            sram_addr  = {word, in_hi};
            sram_oe_n  = op_wr;
            sram_dq_oe = op_wr;
            // WE rises one cycle before the phase ends so data is held past it.
            sram_we_n  = !(op_wr && !timer_zero);
            if (op_wr) begin
                sram_dq_o = in_hi ? wdata[31:16] : wdata[15:0];
            end
        end
    end

    // Request latch and load-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            op_wr     <= 1'b0;
            word      <= '0;
            wdata     <= '0;
            lo_half   <= '0;
            read_data <= '0;
        end else begin
            if (state == IDLE && req) begin
                op_wr <= wr_en;
                word  <= word_in;
                wdata <= write_data;
            end
            if (state == ACC_LO && timer_zero && !op_wr) begin
                lo_half <= sram_dq_i;
            end
            if (state == ACC_HI && timer_zero && !op_wr) begin
                read_data <= {sram_dq_i, lo_half};
            end
        end
    end

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    // Set on the faulting accept edge, so it is high exactly in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= (state == IDLE) && req && range_fault;
        end
    end
`endif

    assign ready = ((state == IDLE) && !req) || (state == DONE);

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_ctrl
// Self-checking bench for sram_mem_ctrl. A transaction-level model (expected
// SRAM image, expected load result, expected pin activity per cycle index
// derived from the latency rules) is compared against the DUT every cycle.
// A second instance with WAIT_CYCLES=3 checks the longer timing directly.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_mem_ctrl;
    import sram_ctrl_pkg::*;

    localparam logic [31:0] BASE   = 32'd1024;
    localparam int          AW     = 10;
    localparam int          WORDS  = 1 << (AW - 1);
    localparam int          HWORDS = 1 << AW;
    localparam int          N      = 1;
    localparam int          N3     = 3;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    localparam bit          RANGE  = 1'b1;
`else
    localparam bit          RANGE  = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic mem_init;

    // main DUT (WAIT_CYCLES = 1)
    logic          rd_en, wr_en;
    logic [31:0]   address, write_data, read_data;
    logic          ready, addr_err;
    logic [AW-1:0] sram_addr;
    logic [15:0]   dq_o, dq_i;
    logic          dq_oe, ce_n, oe_n, we_n;

    // second DUT (WAIT_CYCLES = 3)
    logic          rd3, wr3;
    logic [31:0]   addr3, wdata3, read_data3;
    logic          ready3, addr_err3;
    logic [AW-1:0] sram_addr3;
    logic [15:0]   dq_o3, dq_i3;
    logic          dq_oe3, ce_n3, oe_n3, we_n3;

    sram_mem_ctrl #(.BASE_ADDR(BASE), .SRAM_ADDR_W(AW), .WAIT_CYCLES(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        .addr_err   (addr_err),
`endif
        .sram_addr  (sram_addr),
        .sram_dq_o  (dq_o),
        .sram_dq_i  (dq_i),
        .sram_dq_oe (dq_oe),
        .sram_ce_n  (ce_n),
        .sram_oe_n  (oe_n),
        .sram_we_n  (we_n)
    );

    sram_mem_ctrl #(.BASE_ADDR(BASE), .SRAM_ADDR_W(AW), .WAIT_CYCLES(N3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd3),
        .wr_en      (wr3),
        .address    (addr3),
        .write_data (wdata3),
        .read_data  (read_data3),
        .ready      (ready3),
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        .addr_err   (addr_err3),
`endif
        .sram_addr  (sram_addr3),
        .sram_dq_o  (dq_o3),
        .sram_dq_i  (dq_i3),
        .sram_dq_oe (dq_oe3),
        .sram_ce_n  (ce_n3),
        .sram_oe_n  (oe_n3),
        .sram_we_n  (we_n3)
    );

`ifndef SRAM_CTRL_RANGE_CHECK_EN
    assign addr_err  = 1'b0;
    assign addr_err3 = 1'b0;
`endif

    // Initial SRAM contents (half-words 2/3 hold a known pattern)
    function automatic logic [15:0] init_val(input int i);
        if (i == 2) return 16'h1234;
        if (i == 3) return 16'hABCD;
        return 16'((i * 40503) ^ 23131);
    endfunction

    // Asynchronous SRAM pad models
    logic [15:0] pad_mem  [HWORDS];
    logic [15:0] pad3_mem [HWORDS];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < HWORDS; i++) pad_mem[i] <= init_val(i);
        end else if (!ce_n && !we_n) begin
            pad_mem[sram_addr] <= dq_oe ? dq_o : 16'hFFFF;
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < HWORDS; i++) pad3_mem[i] <= init_val(i);
        end else if (!ce_n3 && !we_n3) begin
            pad3_mem[sram_addr3] <= dq_oe3 ? dq_o3 : 16'hFFFF;
        end
    end

    assign dq_i  = (!ce_n  && !oe_n ) ? pad_mem[sram_addr]   : 16'hF00D;
    assign dq_i3 = (!ce_n3 && !oe_n3) ? pad3_mem[sram_addr3] : 16'hF00D;

    // Reference model state
    logic [15:0]   ref_mem [HWORDS];
    logic [31:0]   exp_rdata;
    logic          exp_ready, exp_active, exp_ce_n, exp_oe_n, exp_we_n;
    logic          exp_dq_oe, exp_addr_err;
    logic [AW-1:0] exp_addr;
    logic [15:0]   exp_dq_o;
    logic          chk_en;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT against the model on every checked cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",     32'(ready),     32'(exp_ready));
            check("ce_n",      32'(ce_n),      32'(exp_ce_n));
            check("oe_n",      32'(oe_n),      32'(exp_oe_n));
            check("we_n",      32'(we_n),      32'(exp_we_n));
            check("dq_oe",     32'(dq_oe),     32'(exp_dq_oe));
            check("read_data", read_data,      exp_rdata);
            if (exp_active) check("sram_addr", 32'(sram_addr), 32'(exp_addr));
            if (exp_dq_oe)  check("dq_o",      32'(dq_o),      32'(exp_dq_o));
            if (RANGE)      check("addr_err",  32'(addr_err),  32'(exp_addr_err));
        end
    end

    task automatic set_idle_exp();
        exp_ready    = 1'b1;
        exp_active   = 1'b0;
        exp_ce_n     = 1'b1;
        exp_oe_n     = 1'b1;
        exp_we_n     = 1'b1;
        exp_dq_oe    = 1'b0;
        exp_addr_err = 1'b0;
        exp_addr     = '0;
        exp_dq_o     = '0;
    endtask

    // Idle cycles: no request, random don't-care address/data
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en      = 1'b0;
            wr_en      = 1'b0;
            address    = $urandom;
            write_data = $urandom;
            set_idle_exp();
            @(posedge clk); #1;
        end
    endtask

    // One request, cycle index k = 0 is the accept cycle. Enter and leave
    // 1 ns after a rising edge. Also reports ready-low and we_n-low counts.
    task automatic run_req(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, output int stalls, output int we_lows);
        logic [31:0] off;
        bit          fault, is_wr, in_lo, in_hi, last;
        int          hw, lat;
        off    = addr - BASE;
        is_wr  = wr;
        fault  = RANGE && ((addr < BASE) || ((off >> (AW + 1)) != 32'd0));
        hw     = 2 * int'(off[AW:2]);
        lat    = fault ? 1 : 2 * N + 3;
        stalls  = 0;
        we_lows = 0;
        rd_en      = rd;
        wr_en      = wr;
        address    = addr;
        write_data = data;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            in_lo = !fault && (k >= 1) && (k <= N + 1);
            in_hi = !fault && (k >= N + 2) && (k <= 2 * N + 2);
            last  = (k == N + 1) || (k == 2 * N + 2);
            exp_ready    = (k == lat);
            exp_addr_err = fault && (k == lat);
            exp_active   = in_lo || in_hi;
            exp_ce_n     = !exp_active;
            exp_oe_n     = !(exp_active && !is_wr);
            exp_dq_oe    = exp_active && is_wr;
            exp_we_n     = !(exp_active && is_wr && !last);
            exp_addr     = AW'(in_hi ? hw + 1 : hw);
            exp_dq_o     = in_hi ? data[31:16] : data[15:0];
            if (k == lat && !fault) begin
                if (is_wr) begin
                    ref_mem[hw]     = data[15:0];
                    ref_mem[hw + 1] = data[31:16];
                end else begin
                    exp_rdata = {ref_mem[hw + 1], ref_mem[hw]};
                end
            end
            @(negedge clk);
            if (!ready) stalls++;
            if (!we_n)  we_lows++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int          st, wl, sel, op, first_ready, lo_cnt, hi_cnt, mism;
        logic [31:0] a, d, rdata_done;

        chk_en     = 1'b0;
        reset      = 1'b1;
        mem_init   = 1'b1;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = '0;
        write_data = '0;
        rd3        = 1'b0;
        wr3        = 1'b0;
        addr3      = '0;
        wdata3     = '0;
        exp_rdata  = '0;
        set_idle_exp();
        for (int i = 0; i < HWORDS; i++) ref_mem[i] = init_val(i);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_read_data", read_data,        32'h0);
        check("rst_ready",     32'(ready),       32'h1);
        check("rst_ce_n",      32'(ce_n),        32'h1);
        check("rst_oe_n",      32'(oe_n),        32'h1);
        check("rst_we_n",      32'(we_n),        32'h1);
        check("rst_dq_oe",     32'(dq_oe),       32'h0);
        check("rst_sram_addr", 32'(sram_addr),   32'h0);
        check("rst_dq_o",      32'(dq_o),        32'h0);
        reset    = 1'b0;
        mem_init = 1'b0;
        @(posedge clk); #1;

        // Reset during ACC_HI of a write (rewrites word 10's own contents)
        wr_en      = 1'b1;
        address    = BASE + 32'd40;
        write_data = {init_val(21), init_val(20)};
        repeat (N + 2) begin
            @(posedge clk); #1;
        end
        check("abort_hi_we_n", 32'(we_n),      32'h0);
        check("abort_hi_addr", 32'(sram_addr), 32'd21);
        reset = 1'b1;
        wr_en = 1'b0;
        @(posedge clk); #1;
        check("abort_we_n",      32'(we_n),  32'h1);
        check("abort_ce_n",      32'(ce_n),  32'h1);
        check("abort_ready",     32'(ready), 32'h1);
        check("abort_read_data", read_data,  32'h0);
        reset = 1'b0;

        chk_en = 1'b1;
        idle(1);

        // Write 0xDEADBEEF at the base address
        run_req(1'b0, 1'b1, BASE, 32'hDEADBEEF, st, wl);
        check("wr_stall_cycles", 32'(st), 32'd5);
        check("wr_we_low_cycles", 32'(wl), 32'd2);
        check("wr_pad_hw0", 32'(pad_mem[0]), 32'h0000BEEF);
        check("wr_pad_hw1", 32'(pad_mem[1]), 32'h0000DEAD);

        // Read from 1028 (half-words 2/3), then a write must not disturb it
        idle(1);
        run_req(1'b1, 1'b0, BASE + 32'd4, 32'h0, st, wl);
        check("rd_result", read_data, 32'hABCD1234);
        check("rd_stall_cycles", 32'(st), 32'd5);
        run_req(1'b0, 1'b1, BASE + 32'd400, $urandom, st, wl);
        check("rd_held_after_wr", read_data, 32'hABCD1234);

        // rd_en and wr_en together: a write to half-words 4/5
        run_req(1'b1, 1'b1, BASE + 32'd8, 32'h00000001, st, wl);
        check("both_pad_hw4", 32'(pad_mem[4]), 32'h00000001);
        check("both_pad_hw5", 32'(pad_mem[5]), 32'h00000000);
        check("both_rdata",   read_data,       32'hABCD1234);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
        // Out-of-range read: DONE at cycle 1, read_data unchanged
        run_req(1'b1, 1'b0, 32'd512, 32'h0, st, wl);
        check("range_stall_cycles", 32'(st), 32'd1);
        check("range_rdata", read_data, 32'hABCD1234);
`endif

        // WAIT_CYCLES=3 instance: read from 1028
        idle(1);
        rd3         = 1'b1;
        addr3       = BASE + 32'd4;
        first_ready = -1;
        lo_cnt      = 0;
        hi_cnt      = 0;
        rdata_done  = '0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin
                set_idle_exp();
                @(posedge clk); #1;
            end
            if (first_ready >= 0) rd3 = 1'b0;
            @(negedge clk);
            if (ready3 && first_ready < 0) begin
                first_ready = k;
                rdata_done  = read_data3;
            end
            if (!ce_n3 && !oe_n3 && sram_addr3 == AW'(2)) lo_cnt++;
            if (!ce_n3 && !oe_n3 && sram_addr3 == AW'(3)) hi_cnt++;
        end
        check("n3_done_cycle", 32'(first_ready), 32'd9);
        check("n3_lo_cycles",  32'(lo_cnt),      32'd4);
        check("n3_hi_cycles",  32'(hi_cnt),      32'd4);
        check("n3_result",     rdata_done,       32'hABCD1234);
        @(posedge clk); #1;

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                a = BASE - 32'(4 * $urandom_range(1, 64)) + 32'($urandom_range(0, 3));
            end else if (sel == 1) begin
                a = BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, WORDS - 1));
            end else if (sel == 2) begin
                a = $urandom;
            end else begin
                a = BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(0, 3));
            end
            d  = $urandom;
            op = $urandom_range(0, 3);
            run_req(op != 2, op >= 2, a, d, st, wl);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        idle(2);
        chk_en = 1'b0;
        mism = 0;
        for (int i = 0; i < HWORDS; i++) begin
            if (pad_mem[i] !== ref_mem[i]) mism++;
        end
        check("sram_image_mismatches", 32'(mism), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Memory-stage SRAM controller. Consumes the execute stage's ALU_result as a byte address, plus the store value (Val_Rm) and the MEM_R_EN / MEM_W_EN controls.
- Performs one 32-bit load or store against an external 16-bit asynchronous SRAM as two half-word phases.
- Drops `ready` while busy; the hazard/freeze logic uses `ready` to stall IF/ID/EX and the pipeline registers.
- Returns load data to the MEM/WB register.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- SRAM_ADDR_W, 18: SRAM half-word address width.
- WAIT_CYCLES, 1: extra hold cycles per half-word phase; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rd_en  in  1  load request (MEM_R_EN).
- wr_en  in  1  store request (MEM_W_EN).
- address  in  32  byte address (ALU_result).
- write_data  in  32  store data (Val_Rm).
- read_data  out  32  load result, registered.
- ready  out  1  0 = freeze pipeline.
- sram_addr  out  SRAM_ADDR_W  half-word address.
- sram_dq_o  out  16  write data to pad.
- sram_dq_i  in  16  read data from pad.
- sram_dq_oe  out  1  pad driver enable.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; read_data=0; sram_ce_n=1, sram_oe_n=1, sram_we_n=1; sram_dq_oe=0; sram_addr=0; sram_dq_o=0.
- Reset mid-access aborts the access immediately; the pin controls are deasserted in the next cycle.
- States: IDLE, ACC_LO, ACC_HI, DONE.
- IDLE:
  - If rd_en|wr_en, latch the request into internal registers and go to ACC_LO with cnt=WAIT_CYCLES.
  - Latched fields: op = wr_en (write wins if both are high), word = (address-BASE_ADDR)>>2 truncated to SRAM_ADDR_W-1 bits, wdata = write_data.
- ACC_LO: sram_addr={word,1'b0}. Decrement cnt; when cnt==0, go to ACC_HI and reload cnt=WAIT_CYCLES. For a read, capture sram_dq_i into lo_half on that exit edge.
- ACC_HI: sram_addr={word,1'b1}. Same countdown. For a read, capture sram_dq_i into read_data[31:16] and load lo_half into read_data[15:0] on the exit edge. Then go to DONE.
- DONE: one cycle, then IDLE unconditionally.
- ready is combinational: ready = (state==IDLE && !(rd_en|wr_en)) || state==DONE.
  - The frozen pipeline holds the request stable from acceptance through DONE.
  - In DONE the pipeline advances; the next request is sampled in IDLE on the following cycle. There are no back-to-back accepts without an IDLE cycle.
- Latency with N=WAIT_CYCLES (accept cycle = 0):
  - ACC_LO occupies cycles 1..N+1.
  - ACC_HI occupies cycles N+2..2N+2.
  - DONE is cycle 2N+3.
  - The request stalls the pipeline for 2N+3 cycles.
- SRAM pins, decoded from state and the latched op:
  - sram_ce_n=0 in ACC_LO/ACC_HI.
  - Read: sram_oe_n=0, sram_we_n=1, sram_dq_oe=0.
  - Write: sram_oe_n=1, sram_dq_oe=1, sram_dq_o=wdata[15:0] in ACC_LO and wdata[31:16] in ACC_HI. sram_we_n=0 except on the final cycle of each phase (cnt==0), giving data hold before WE rises.
  - All pins are inactive in IDLE/DONE.
- read_data holds its value until the next read completes. Writes never change read_data.
- Address bits [1:0] are ignored (word access only). Addresses below BASE_ADDR wrap modulo 2^(SRAM_ADDR_W-1) unless the optional feature is enabled.

Optional Feature:
- Macro: SRAM_CTRL_RANGE_CHECK_EN.
- With the macro:
  - Adds output `addr_err` (1 bit, reset 0).
  - A request whose address < BASE_ADDR, or whose word index overflows SRAM_ADDR_W-1 bits, skips ACC_LO/ACC_HI and goes IDLE->DONE. The pins stay inactive.
  - addr_err=1 during that DONE cycle only. A faulting read leaves read_data unchanged.
- Without the macro: no addr_err port; such addresses wrap as stated above.

Decomposition:
- Package sram_ctrl_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, ACC_LO, ACC_HI, DONE};
  - localparam CNT_W=4;
  - the DEFAULT_BASE_ADDR=1024 constant.
- One natural sub-module, sram_phase_timer: a loadable down-counter with a `zero` flag, shared by both phases.

Test Plan:
- Reset while in ACC_HI of a write -> next cycle state=IDLE, sram_we_n=1, sram_ce_n=1, ready=1, read_data=0.
- Write address=1024, data=0xDEADBEEF, N=1 -> sram_addr=0 then 1, dq_o=0xBEEF then 0xDEAD, we_n low exactly 1 cycle per phase, ready low cycles 0..4, high cycle 5.
- Read address=1028 with model holding 0x1234 at half-word 2 and 0xABCD at half-word 3 -> read_data=0xABCD1234 in DONE (cycle 5), held through a following write.
- rd_en=wr_en=1, address=1032, data=0x00000001 -> treated as write: half-words 4/5 written, read_data unchanged.
- N=3 read -> DONE at cycle 9, each phase 4 cycles, oe_n low throughout both phases.
- With SRAM_CTRL_RANGE_CHECK_EN, read address=512 -> DONE at cycle 1, addr_err=1 for one cycle, ce_n never asserted, read_data unchanged.
